serial_add_ctrl: RTL and testbench

- Bit-serial W-bit adder controller that time-shares a single one-bit full-adder cell across all operand bits, LSB first.
- Handshake: start/busy/done.
- Sits between a requester and the shared adder cell, sequencing operand shifting and carry propagation.
- Used where area matters more than latency.

---
 rtl/serial_add_pkg.sv | 11 +
 rtl/fa_bit_cell.sv | 15 +
 rtl/half_adder.sv | 10 +
 rtl/serial_add_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam int         SA_W        = 8;
   localparam logic [7:0] ERR_CNT_MAX = 8'd255;
endpackage

// File: rtl/fa_bit_cell.sv
// Combinational one-bit full adder: two half adders plus an OR for the carry.
module fa_bit_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   logic w_s1, w_c1, w_c2;

   half_adder u_ha0 (.i_a(i_a),  .i_b(i_b), .o_s(w_s1), .o_c(w_c1));
   half_adder u_ha1 (.i_a(w_s1), .i_b(i_c), .o_s(o_s),  .o_c(w_c2));

   assign o_c = w_c1 | w_c2;
endmodule

// File: rtl/half_adder.sv
// One-bit half adder.
module half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b;
   assign o_c = i_a & i_b;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder sequencing one shared full-adder cell, LSB first.
// Optional SERIAL_ADD_SELFCHECK_EN adds a parallel reference check (mismatch, err_cnt).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int W = SA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
`ifdef SERIAL_ADD_SELFCHECK_EN
   ,
   output logic         mismatch,
   output logic [7:0]   err_cnt
`endif
);
   localparam int CW = $clog2(W);

   state_t          r_state;
   logic [W-1:0]    r_a_sr, r_b_sr, r_res, r_sum;
   logic            r_carry, r_busy, r_done, r_cout;
   logic [CW-1:0]   r_cnt;
   logic            w_s, w_co, w_accept;

`ifdef SERIAL_ADD_SELFCHECK_EN
   logic [W-1:0]    r_a_lat, r_b_lat;
   logic            r_cin_lat, r_mismatch;
   logic [7:0]      r_err_cnt;
   logic [W:0]      w_ref;
   logic            w_mis;

   assign w_ref = {1'b0, r_a_lat} + {1'b0, r_b_lat} + {{W{1'b0}}, r_cin_lat};
   assign w_mis = ({r_carry, r_res} != w_ref);
   assign mismatch = r_mismatch;
   assign err_cnt  = r_err_cnt;
`endif

   fa_bit_cell u_fa (
      .i_a(r_a_sr[0]),
      .i_b(r_b_sr[0]),
      .i_c(r_carry),
      .o_s(w_s),
      .o_c(w_co)
   );

   // DONE doubles as an accept slot so back-to-back requests cost W+1 cycles.
   assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
`ifdef SERIAL_ADD_SELFCHECK_EN
         r_a_lat    <= '0;
         r_b_lat    <= '0;
         r_cin_lat  <= 1'b0;
         r_mismatch <= 1'b0;
         r_err_cnt  <= '0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef SERIAL_ADD_SELFCHECK_EN
         r_mismatch <= 1'b0;
`endif
         case (r_state)
            S_IDLE: ;
            S_SHIFT: begin
               r_a_sr  <= {1'b0, r_a_sr[W-1:1]};
               r_b_sr  <= {1'b0, r_b_sr[W-1:1]};
               r_res   <= {w_s, r_res[W-1:1]};
               r_carry <= w_co;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == CW'(W-1)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
               end
            end
            S_DONE: begin
               r_sum   <= r_res;
               r_cout  <= r_carry;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
`ifdef SERIAL_ADD_SELFCHECK_EN
               r_mismatch <= w_mis;
               if (w_mis && (r_err_cnt != ERR_CNT_MAX))
                  r_err_cnt <= r_err_cnt + 8'd1;
`endif
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
`ifdef SERIAL_ADD_SELFCHECK_EN
            r_a_lat   <= a;
            r_b_lat   <= b;
            r_cin_lat <= cin;
`endif
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (W=8): vector table plus multi-cycle corner sequences.
module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout;
   logic [W-1:0] sum;
`ifdef SERIAL_ADD_SELFCHECK_EN
   logic         mismatch;
   logic [7:0]   err_cnt;
`endif

   int tests = 0;
   int fails = 0;

   serial_add_ctrl #(.W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_SELFCHECK_EN
      , .mismatch(mismatch), .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a, b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One isolated addition: checks busy length, done latency, pulse width and result.
   task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic [W-1:0] es, input logic ec);
      int lat, bcnt;
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_; cin = tc;
      @(posedge clk); #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      lat = 0; bcnt = busy ? 1 : 0;
      while (!done && lat < 30) begin
         @(posedge clk); #1;
         lat++;
         if (busy) bcnt++;
      end
      check({name, "_latency"}, lat, 9);
      check({name, "_busy_cycles"}, bcnt, 8);
      check({name, "_sum"}, sum, es);
      check({name, "_cout"}, cout, ec);
      @(posedge clk); #1;
      check({name, "_done_pulse"}, done, 0);
   endtask

   initial begin
      int bad, dcnt, n;
      logic [W-1:0] cs, ra, rb, na, nb;
      logic cc, rc, nc;
      logic [W:0] exp_q [$];

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[3] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
      vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
      vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

      #12;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_sum", sum, 0);
      check("reset_cout", cout, 0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 7; i++)
         do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

      // Last vector was FF+FF+1: outputs must hold while idle.
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || sum !== 8'hFF || cout !== 1'b1) bad++;
      end
      check("hold_idle", bad, 0);

      // Start while busy is ignored.
      @(negedge clk); start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      dcnt = 0; cs = '0; cc = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (done) begin dcnt++; cs = sum; cc = cout; end
      end
      check("ignore_done_count", dcnt, 1);
      check("ignore_sum", cs, 8'h07);
      check("ignore_cout", cc, 0);

      // Reset in the middle of SHIFT.
      @(negedge clk); start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_sum", sum, 0);
      check("midrst_cout", cout, 0);
      @(negedge clk); rst = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done || busy) dcnt++;
      end
      check("midrst_quiet", dcnt, 0);
      do_op("after_rst", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

      // Back-to-back with start held high.
`ifdef SERIAL_ADD_SELFCHECK_EN
      n = 256;
`else
      n = 16;
`endif
      bad = 0;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      exp_q.push_back({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
      @(negedge clk); start = 1'b1; a = ra; b = rb; cin = rc;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         logic [W:0] e;
         repeat (8) begin
            @(posedge clk); #1;
            if (done) bad++;
         end
         @(negedge clk);
         if (i == n-1) start = 1'b0;
         else begin
            na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
            a = na; b = nb; cin = nc;
            exp_q.push_back({1'b0, na} + {1'b0, nb} + {{W{1'b0}}, nc});
         end
         @(posedge clk); #1;
         e = exp_q.pop_front();
         if (done !== 1'b1 || {cout, sum} !== e) begin
            if (bad < 4)
               $display("FAIL b2b_%0d: got done=%0b result=%0h expected done=1 result=%0h", i, done, {cout, sum}, e);
            bad++;
         end
`ifdef SERIAL_ADD_SELFCHECK_EN
         if (mismatch !== 1'b0) bad++;
`endif
      end
      check("b2b_errors", bad, 0);
`ifdef SERIAL_ADD_SELFCHECK_EN
      check("selfcheck_err_cnt", err_cnt, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
